// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared types, range encodings and gate/scale helpers for freq_gate_ctrl
package freq_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, GATE, SCALE, DONE} state_t;

    localparam logic [1:0] RANGE_1S    = 2'd0;
    localparam logic [1:0] RANGE_100MS = 2'd1;
    localparam logic [1:0] RANGE_10MS  = 2'd2;

    localparam int unsigned SCALE_1S    = 1;
    localparam int unsigned SCALE_100MS = 10;
    localparam int unsigned SCALE_10MS  = 100;

    // Reserved encoding 3 falls through to the 1 s gate.
    function automatic logic [31:0] gate_cycles(input int unsigned clk_hz, input logic [1:0] rng);
        case (rng)
            RANGE_100MS: return 32'(clk_hz / 10);
            RANGE_10MS:  return 32'(clk_hz / 100);
            default:     return 32'(clk_hz);
        endcase
    endfunction

    function automatic int unsigned scale_of(input logic [1:0] rng);
        case (rng)
            RANGE_100MS: return SCALE_100MS;
            RANGE_10MS:  return SCALE_10MS;
            default:     return SCALE_1S;
        endcase
    endfunction

endpackage

// File: rtl/freq_gate_ctrl_in_sync_edge.sv
// rtl/freq_gate_ctrl_in_sync_edge.sv - 2-flop synchronizer with rising-edge pulse
module in_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_gate_ctrl.sv
// rtl/freq_gate_ctrl.sv - gate-time sequencer: counts input edges in a window and scales to Hz
module freq_gate_ctrl
    import freq_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             start,
    input  logic             cont,
    input  logic [1:0]       range_sel,
    output logic             busy,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow
);

    localparam int unsigned WW = CNT_W + 7;
    localparam logic [WW-1:0] MAX_W = WW'({CNT_W{1'b1}});

    state_t           state_q, state_d;
    logic             rise;
    logic [1:0]       rng_q;
    logic [31:0]      gate_cnt;
    logic [CNT_W-1:0] count;
    logic             sat;
    logic [CNT_W-1:0] result;
    logic             res_ovf;
    logic [WW-1:0]    c_ext, x10, x100, scaled;
    logic             too_big;

    in_sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .rise  (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start || cont) state_d = CLEAR;
            CLEAR:   state_d = GATE;
            GATE:    if (gate_cnt == 32'd0) state_d = SCALE;
            SCALE:   state_d = DONE;
            DONE:    state_d = cont ? CLEAR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // Shift-add scaling at CNT_W+7 bits so x100 never wraps before the saturation test.
    assign c_ext = WW'(count);
    assign x10   = (c_ext << 3) + (c_ext << 1);
    assign x100  = (c_ext << 6) + (c_ext << 5) + (c_ext << 2);

    always_comb begin
        scaled = c_ext;
        case (scale_of(rng_q))
            SCALE_100MS: scaled = x10;
            SCALE_10MS:  scaled = x100;
            default:     scaled = c_ext;
        endcase
    end

    assign too_big = sat || (scaled > MAX_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rng_q      <= RANGE_1S;
            gate_cnt   <= '0;
            count      <= '0;
            sat        <= 1'b0;
            result     <= '0;
            res_ovf    <= 1'b0;
            freq       <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (state_q)
                CLEAR: begin
                    count    <= '0;
                    sat      <= 1'b0;
                    gate_cnt <= gate_cycles(CLK_HZ, range_sel) - 32'd1;
                    rng_q    <= (range_sel == 2'd3) ? RANGE_1S : range_sel;
                end
                GATE: begin
                    if (gate_cnt != 32'd0) gate_cnt <= gate_cnt - 32'd1;
                    if (rise) begin
                        if (count == {CNT_W{1'b1}}) sat <= 1'b1;
                        else                        count <= count + 1'b1;
                    end
                end
                SCALE: begin
                    result  <= too_big ? {CNT_W{1'b1}} : scaled[CNT_W-1:0];
                    res_ovf <= too_big;
                end
                DONE: begin
                    freq       <= result;
                    overflow   <= res_ovf;
                    freq_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
